cam_cfg_sequencer: RTL and testbench
====================================

Name: cam_cfg_sequencer

Overview:
- Boots the camera sensor by walking an external register table of {reg, value} entries and issuing one I2C write per entry to the i2c_core request interface; handles delay and end markers, NACK retry and a stuck-core timeout.
- After boot completes, arbitrates the same i2c_core between host single-register requests (AXI-side register block) and software re-runs of the table.
- Sits between camera_axi-level control logic and i2c_core, in the fast clk domain.

Parameters:
- I2C_ADDR, 8'h60, 8-bit sensor address; bit0 is forced 0 for writes and 1 for reads.
- TBL_AW, 8, table address width; entries 0..2^TBL_AW-1.
- DELAY_UNIT, 83000, clk cycles per delay tick (1 ms at 83 MHz).
- MAX_RETRY, 3, extra attempts after a NACK before ERR.
- TIMEOUT, 24'hFFFFFF, clk cycles allowed per i2c_core phase before abort.

Ports:
- clk in 1: system clock.
- rst_n in 1: async active-low reset.
- start in 1: pulse; (re)runs the table from entry 0 when in DONE or ERR; ignored otherwise.
- tbl_addr out TBL_AW: table read address.
- tbl_data in 16: {reg[15:8], val[7:0]}; valid 1 cycle after tbl_addr changes (sync ROM).
- host_req in 1: host request; held until host_ack.
- host_rw in 1: 1 = read, 0 = write.
- host_reg in 8: register address.
- host_wdata in 8: write value.
- host_ack out 1: 1-cycle pulse on completion.
- host_rdata out 9: {nack, rx_data}.
- i2c_addr out 8, i2c_cmd out 8, i2c_tx_data out 8, i2c_start_trigger out 1: to i2c_core.
- i2c_busy in 1, i2c_ack in 1 (1 = NACK), i2c_rx_data in 8: from i2c_core.
- done out 1: table completed without error.
- err out 1: retry exhausted or timeout.
- err_idx out TBL_AW: entry index at failure.

Behaviour:
- Reset: state IDLE; all outputs 0 except i2c_addr = I2C_ADDR & 8'hFE. Leaving reset starts a run automatically (IDLE->FETCH on first clk).
- Core handshake, every transaction:
  - Drive addr/cmd/tx_data, then assert i2c_start_trigger.
  - Hold trigger until i2c_busy is sampled 1, then drop it.
  - Transaction is complete when i2c_busy is sampled 0. i2c_busy comes from a slow domain; sample it through a 2-flop synchroniser.
  - Capture i2c_ack and i2c_rx_data on the busy falling edge.
- States:
  - FETCH: drive tbl_addr = idx; 1 wait cycle.
  - DECODE:
    - reg == 8'hFF: go to DONE.
    - reg == 8'hFE: go to DELAY, loading val*DELAY_UNIT into the counter.
    - Otherwise: go to TRIG.
  - TRIG: trigger asserted; go to WAIT on synchronised busy = 1.
  - WAIT: on busy = 0:
    - NACK and retry < MAX_RETRY: retry++, return to TRIG.
    - NACK and retries exhausted: go to ERR.
    - ACK: retry = 0, idx++, go to FETCH.
  - DELAY: counter decrements each cycle; at 0, idx++ and go to FETCH. A val of 0 gives no wait (next cycle).
  - DONE: done = 1. A pending host_req takes priority over start (host first, start is remembered); serve via H_TRIG/H_WAIT, then pulse host_ack and return to DONE.
  - ERR: err = 1, err_idx latched. Host requests are still served. start clears err and reruns.
- host_req while a table run is in progress is stalled, with no ack, until DONE/ERR.
- idx wraps from 2^TBL_AW-1 to 0 with no end marker: treated as end; go to DONE.
- Timeout counter is reset at each TRIG/WAIT entry. Expiry forces trigger to 0 and enters ERR (table run) or acks the host with nack = 1 (host request).
- Async reset mid-transaction aborts at once; i2c_core is reset by the same source.

Optional Feature:
- CAM_CFG_READBACK_EN defined: after each ACKed table write, issue a read of the same register. rx != val counts as a failure, using the same retry path (write + read retried). err_idx reports the entry.
- Undefined: writes only, no read cycle.

Test Plan:
- Table {12h:80h}, {FEh:02h}, {11h:01h}, {FFh:xx}, model always ACKs -> two writes with addr 60h, a gap of 2*DELAY_UNIT cycles between them, then done = 1 with err = 0.
- Model NACKs entry 1 three times then ACKs, MAX_RETRY = 3 -> 4 attempts, run completes with done = 1.
- Model always NACKs entry 2 -> 4 attempts, then err = 1, err_idx = 2, done = 0.
- After done, host read reg 0Ah, model returns 76h -> i2c_addr = 61h, host_rdata = 9'h076, host_ack pulses for 1 cycle.
- host_req asserted at the same cycle as start in DONE -> host served first, then the table reruns from idx 0.
- busy held 0 after trigger (core dead) -> err = 1 after TIMEOUT; rst_n low mid-WAIT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/cam_cfg_sequencer.sv
// Camera sensor boot sequencer: walks a {reg,val} table into i2c_core, then serves host accesses.
// Optional CAM_CFG_READBACK_EN: read back every ACKed table write and compare against the table value.
module cam_cfg_sequencer #(
    parameter logic [7:0]  I2C_ADDR   = 8'h60,
    parameter int          TBL_AW     = 8,
    parameter int          DELAY_UNIT = 83000,
    parameter int          MAX_RETRY  = 3,
    parameter logic [23:0] TIMEOUT    = 24'hFFFFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [15:0]       tbl_data,
    input  logic              host_req,
    input  logic              host_rw,
    input  logic [7:0]        host_reg,
    input  logic [7:0]        host_wdata,
    output logic              host_ack,
    output logic [8:0]        host_rdata,
    output logic [7:0]        i2c_addr,
    output logic [7:0]        i2c_cmd,
    output logic [7:0]        i2c_tx_data,
    output logic              i2c_start_trigger,
    input  logic              i2c_busy,
    input  logic              i2c_ack,
    input  logic [7:0]        i2c_rx_data,
    output logic              done,
    output logic              err,
    output logic [TBL_AW-1:0] err_idx
);

    localparam logic [7:0]  ADDR_WR   = I2C_ADDR & 8'hFE;
    localparam logic [7:0]  ADDR_RD   = I2C_ADDR | 8'h01;
    localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);
    localparam logic [31:0] DLY_UNIT  = 32'(DELAY_UNIT);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_TRIG, S_WAIT,
        S_DELAY, S_DONE, S_ERR, S_H_TRIG, S_H_WAIT
    } state_t;

    state_t            state_q;
    logic [TBL_AW-1:0] idx_q;
    logic [7:0]        retry_q;
    logic [31:0]       dly_q;
    logic [23:0]       to_q;
    logic              busy_s1_q;
    logic              busy_s2_q;
    logic              start_pend_q;
    logic              host_ack_q;
    logic [8:0]        host_rdata_q;
    logic [7:0]        addr_q;
    logic [7:0]        cmd_q;
    logic [7:0]        tx_q;
    logic              trig_q;
    logic              done_q;
    logic              err_q;
    logic [TBL_AW-1:0] err_idx_q;
`ifdef CAM_CFG_READBACK_EN
    logic              rd_phase_q;
`endif

    logic       to_hit;
    logic       txn_fail;
    logic [7:0] tbl_reg;
    logic [7:0] tbl_val;

    assign to_hit  = (to_q == TIMEOUT);
    assign tbl_reg = tbl_data[15:8];
    assign tbl_val = tbl_data[7:0];

    // A readback mismatch is folded into the NACK so it shares the retry path
    always_comb begin
        txn_fail = i2c_ack;
`ifdef CAM_CFG_READBACK_EN
        if (rd_phase_q && (i2c_rx_data != tx_q)) txn_fail = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            retry_q      <= '0;
            dly_q        <= '0;
            to_q         <= '0;
            busy_s1_q    <= 1'b0;
            busy_s2_q    <= 1'b0;
            start_pend_q <= 1'b0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
            addr_q       <= ADDR_WR;
            cmd_q        <= '0;
            tx_q         <= '0;
            trig_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_idx_q    <= '0;
`ifdef CAM_CFG_READBACK_EN
            rd_phase_q   <= 1'b0;
`endif
        end else begin
            busy_s1_q  <= i2c_busy;
            busy_s2_q  <= busy_s1_q;
            host_ack_q <= 1'b0;
            unique case (state_q)
                S_IDLE:  state_q <= S_FETCH;
                S_FETCH: state_q <= S_DECODE;
                S_DECODE: begin
                    if (tbl_reg == 8'hFF) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (tbl_reg == 8'hFE) begin
                        dly_q   <= 32'(tbl_val) * DLY_UNIT;
                        state_q <= S_DELAY;
                    end else begin
                        addr_q  <= ADDR_WR;
                        cmd_q   <= tbl_reg;
                        tx_q    <= tbl_val;
                        trig_q  <= 1'b1;
                        to_q    <= '0;
                        state_q <= S_TRIG;
                    end
                end
                S_TRIG: begin
                    if (to_hit) begin
                        trig_q    <= 1'b0;
                        err_q     <= 1'b1;
                        err_idx_q <= idx_q;
                        state_q   <= S_ERR;
                    end else if (busy_s2_q) begin
                        trig_q  <= 1'b0;
                        to_q    <= '0;
                        state_q <= S_WAIT;
                    end else begin
                        to_q <= to_q + 24'd1;
                    end
                end
                S_WAIT: begin
                    if (to_hit) begin
                        err_q     <= 1'b1;
                        err_idx_q <= idx_q;
                        state_q   <= S_ERR;
                    end else if (!busy_s2_q) begin
                        if (txn_fail) begin
                            if (retry_q < RETRY_MAX) begin
                                retry_q <= retry_q + 8'd1;
                                addr_q  <= ADDR_WR;
                                trig_q  <= 1'b1;
                                to_q    <= '0;
                                state_q <= S_TRIG;
`ifdef CAM_CFG_READBACK_EN
                                rd_phase_q <= 1'b0;
`endif
                            end else begin
                                err_q     <= 1'b1;
                                err_idx_q <= idx_q;
                                state_q   <= S_ERR;
                            end
`ifdef CAM_CFG_READBACK_EN
                        end else if (!rd_phase_q) begin
                            rd_phase_q <= 1'b1;
                            addr_q     <= ADDR_RD;
                            trig_q     <= 1'b1;
                            to_q       <= '0;
                            state_q    <= S_TRIG;
`endif
                        end else begin
`ifdef CAM_CFG_READBACK_EN
                            rd_phase_q <= 1'b0;
`endif
                            retry_q <= '0;
                            idx_q   <= idx_q + 1'b1;
                            if (&idx_q) begin
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                state_q <= S_FETCH;
                            end
                        end
                    end else begin
                        to_q <= to_q + 24'd1;
                    end
                end
                S_DELAY: begin
                    if (dly_q == '0) begin
                        idx_q <= idx_q + 1'b1;
                        if (&idx_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end else begin
                        dly_q <= dly_q - 32'd1;
                    end
                end
                S_DONE, S_ERR: begin
                    // host_ack_q blocks re-serving a request the host has not yet dropped
                    if (host_req && !host_ack_q) begin
                        start_pend_q <= start_pend_q | start;
                        addr_q       <= host_rw ? ADDR_RD : ADDR_WR;
                        cmd_q        <= host_reg;
                        tx_q         <= host_wdata;
                        trig_q       <= 1'b1;
                        to_q         <= '0;
                        state_q      <= S_H_TRIG;
                    end else if (start || start_pend_q) begin
                        start_pend_q <= 1'b0;
                        done_q       <= 1'b0;
                        err_q        <= 1'b0;
                        idx_q        <= '0;
                        retry_q      <= '0;
                        state_q      <= S_FETCH;
                    end
                end
                S_H_TRIG: begin
                    if (to_hit) begin
                        trig_q       <= 1'b0;
                        host_ack_q   <= 1'b1;
                        host_rdata_q <= 9'h100;
                        state_q      <= err_q ? S_ERR : S_DONE;
                    end else if (busy_s2_q) begin
                        trig_q  <= 1'b0;
                        to_q    <= '0;
                        state_q <= S_H_WAIT;
                    end else begin
                        to_q <= to_q + 24'd1;
                    end
                end
                S_H_WAIT: begin
                    if (to_hit) begin
                        host_ack_q   <= 1'b1;
                        host_rdata_q <= 9'h100;
                        state_q      <= err_q ? S_ERR : S_DONE;
                    end else if (!busy_s2_q) begin
                        host_ack_q   <= 1'b1;
                        host_rdata_q <= {i2c_ack, i2c_rx_data};
                        state_q      <= err_q ? S_ERR : S_DONE;
                    end else begin
                        to_q <= to_q + 24'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tbl_addr          = idx_q;
    assign host_ack          = host_ack_q;
    assign host_rdata        = host_rdata_q;
    assign i2c_addr          = addr_q;
    assign i2c_cmd           = cmd_q;
    assign i2c_tx_data       = tx_q;
    assign i2c_start_trigger = trig_q;
    assign done              = done_q;
    assign err               = err_q;
    assign err_idx           = err_idx_q;

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Bench for cam_cfg_sequencer: sync-ROM table, behavioural i2c_core, table-walk reference model.
module tb_cam_cfg_sequencer;

    localparam int          AW = 4;
    localparam int          N  = 16;
    localparam int          DU = 50;
    localparam int          MR = 3;
    localparam logic [23:0] TO = 24'd200;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] tbl_addr;
    logic [15:0]   tbl_data;
    logic          host_req = 1'b0;
    logic          host_rw = 1'b0;
    logic [7:0]    host_reg = '0;
    logic [7:0]    host_wdata = '0;
    logic          host_ack;
    logic [8:0]    host_rdata;
    logic [7:0]    i2c_addr;
    logic [7:0]    i2c_cmd;
    logic [7:0]    i2c_tx_data;
    logic          i2c_start_trigger;
    logic          i2c_busy;
    logic          i2c_ack;
    logic [7:0]    i2c_rx_data;
    logic          done;
    logic          err;
    logic [AW-1:0] err_idx;

    always #5 clk = ~clk;

    cam_cfg_sequencer #(
        .I2C_ADDR(8'h60), .TBL_AW(AW), .DELAY_UNIT(DU),
        .MAX_RETRY(MR), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .host_req(host_req), .host_rw(host_rw), .host_reg(host_reg),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .i2c_addr(i2c_addr), .i2c_cmd(i2c_cmd), .i2c_tx_data(i2c_tx_data),
        .i2c_start_trigger(i2c_start_trigger), .i2c_busy(i2c_busy),
        .i2c_ack(i2c_ack), .i2c_rx_data(i2c_rx_data),
        .done(done), .err(err), .err_idx(err_idx)
    );

    logic [15:0] rom [N];
    always @(posedge clk) tbl_data <= rom[tbl_addr];

    // Behavioural i2c_core: per-register NACK budget, sticky NACK, or dead core
    bit          dead;
    int          nack_left [256];
    bit          nack_always [256];
    logic [7:0]  mem [256];
    logic [23:0] log_q [$];
    int          log_cyc [$];
    int          cyc = 0;
    int          mstate;
    int          mcnt;
    logic        nx_ack;
    logic [7:0]  nx_rx;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstate      <= 0;
            mcnt        <= 0;
            i2c_busy    <= 1'b0;
            i2c_ack     <= 1'b0;
            i2c_rx_data <= '0;
            nx_ack      <= 1'b0;
            nx_rx       <= '0;
        end else begin
            case (mstate)
                0: if (i2c_start_trigger && !dead) begin
                    log_q.push_back({i2c_addr, i2c_cmd, i2c_tx_data});
                    log_cyc.push_back(cyc);
                    if (i2c_addr[0]) begin
                        nx_ack <= 1'b0;
                        nx_rx  <= mem[i2c_cmd];
                    end else if (nack_always[i2c_cmd]) begin
                        nx_ack <= 1'b1;
                    end else if (nack_left[i2c_cmd] > 0) begin
                        nx_ack <= 1'b1;
                        nack_left[i2c_cmd] = nack_left[i2c_cmd] - 1;
                    end else begin
                        nx_ack <= 1'b0;
                        mem[i2c_cmd] = i2c_tx_data;
                    end
                    mcnt   <= $urandom_range(0, 3);
                    mstate <= 1;
                end
                1: if (mcnt == 0) begin
                    i2c_busy <= 1'b1;
                    mstate   <= 2;
                end else mcnt <= mcnt - 1;
                2: if (!i2c_start_trigger) begin
                    mcnt   <= $urandom_range(2, 8);
                    mstate <= 3;
                end
                default: if (mcnt == 0) begin
                    i2c_ack     <= nx_ack;
                    i2c_rx_data <= nx_rx;
                    i2c_busy    <= 1'b0;
                    mstate      <= 0;
                end else mcnt <= mcnt - 1;
            endcase
        end
    end

    // Reference: expected write list and outcome, straight from the table rules
    logic [23:0] exp_q [$];
    bit          exp_done;
    bit          exp_err;
    int          exp_idx;

    task automatic ref_run();
        int         left [256];
        logic [7:0] r;
        logic [7:0] v;
        bit         ok;
        exp_q.delete();
        exp_done = 0;
        exp_err  = 0;
        exp_idx  = 0;
        foreach (left[i]) left[i] = nack_left[i];
        for (int n = 0; n < N; n++) begin
            r = rom[n][15:8];
            v = rom[n][7:0];
            if (r == 8'hFF) begin
                exp_done = 1;
                return;
            end
            if (r == 8'hFE) continue;
            ok = 0;
            for (int a = 0; a <= MR; a++) begin
                exp_q.push_back({8'h60, r, v});
                if (nack_always[r]) continue;
                if (left[r] > 0) begin
                    left[r]--;
                    continue;
                end
                ok = 1;
                break;
            end
            if (!ok) begin
                exp_err = 1;
                exp_idx = n;
                return;
            end
        end
        exp_done = 1;
    endtask

    int checks = 0;
    int errors = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_fin(string tag, int bound);
        int k = 0;
        while (!(done || err) && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_end"}, 32'(done | err), 32'd1);
    endtask

    task automatic check_run(string tag);
        int n;
        chk({tag, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk({tag, "_txn"}, 32'(log_q[i]), 32'(exp_q[i]));
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        if (exp_err) chk({tag, "_idx"}, 32'(err_idx), 32'(exp_idx));
    endtask

    task automatic clear_env();
        for (int i = 0; i < 256; i++) begin
            nack_left[i]   = 0;
            nack_always[i] = 0;
        end
    endtask

    task automatic fill_end();
        for (int i = 0; i < N; i++) rom[i] = 16'hFF00;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_run(string tag);
        ref_run();
        log_q.delete();
        log_cyc.delete();
        pulse_start();
        wait_fin(tag, 6000);
        check_run(tag);
    endtask

    task automatic host_txn(string tag, logic rw, logic [7:0] r, logic [7:0] wd,
                            output logic [8:0] rd);
        int k = 0;
        log_q.delete();
        @(negedge clk);
        host_rw    = rw;
        host_reg   = r;
        host_wdata = wd;
        host_req   = 1'b1;
        while (!host_ack && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_ack"}, 32'(host_ack), 32'd1);
        rd = host_rdata;
        host_req = 1'b0;
        @(negedge clk);
        chk({tag, "_ack_pulse"}, 32'(host_ack), 32'd0);
    endtask

    initial begin
        logic [8:0] rd;
        int         k;
        int         gap;
        int         len;
        dead = 0;
        clear_env();
        for (int i = 0; i < 256; i++) mem[i] = '0;

        // Boot table with a delay marker; run starts as reset releases
        fill_end();
        rom[0] = 16'h1280;
        rom[1] = 16'hFE02;
        rom[2] = 16'h1101;
        ref_run();
        log_q.delete();
        log_cyc.delete();
        repeat (2) @(negedge clk);
        chk("rst_trig", 32'(i2c_start_trigger), 32'd0);
        chk("rst_addr", 32'(i2c_addr), 32'h60);
        chk("rst_cmd", 32'(i2c_cmd), 32'd0);
        chk("rst_tx", 32'(i2c_tx_data), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_erridx", 32'(err_idx), 32'd0);
        chk("rst_tbladdr", 32'(tbl_addr), 32'd0);
        chk("rst_hack", 32'(host_ack), 32'd0);
        chk("rst_hrdata", 32'(host_rdata), 32'd0);
        rst_n = 1'b1;
        wait_fin("t1", 6000);
        check_run("t1");
        gap = (log_cyc.size() >= 2) ? log_cyc[1] - log_cyc[0] : 0;
        chk("t1_gap_lo", 32'(gap >= 2 * DU + 8), 32'd1);
        chk("t1_gap_hi", 32'(gap <= 2 * DU + 45), 32'd1);

        // Entry 1 NACKs three times, fourth attempt succeeds
        fill_end();
        rom[0] = 16'h2011;
        rom[1] = 16'h2122;
        nack_left[8'h21] = 3;
        do_run("t2");

        // Host read after done
        mem[8'h0A] = 8'h76;
        host_txn("hrd", 1'b1, 8'h0A, 8'h00, rd);
        chk("hrd_data", 32'(rd), 32'h076);
        chk("hrd_n", 32'(log_q.size()), 32'd1);
        if (log_q.size() > 0) chk("hrd_addr", 32'(log_q[0][23:8]), 32'h610A);

        // Entry 2 always NACKs
        clear_env();
        fill_end();
        rom[0] = 16'h3001;
        rom[1] = 16'h3102;
        rom[2] = 16'h3203;
        rom[3] = 16'h3304;
        nack_always[8'h32] = 1;
        do_run("t3");

        // Host write is still served in ERR
        host_txn("hwr", 1'b0, 8'h3C, 8'h5A, rd);
        chk("hwr_nack", 32'(rd[8]), 32'd0);
        chk("hwr_n", 32'(log_q.size()), 32'd1);
        if (log_q.size() > 0) chk("hwr_txn", 32'(log_q[0]), 32'h603C5A);
        chk("hwr_err_kept", 32'(err), 32'd1);

        // host_req and start together: host first, then rerun from 0
        clear_env();
        fill_end();
        rom[0] = 16'h4411;
        rom[1] = 16'h4522;
        do_run("pre");
        ref_run();
        log_q.delete();
        @(negedge clk);
        host_rw    = 1'b0;
        host_reg   = 8'h55;
        host_wdata = 8'h9A;
        host_req   = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!host_ack && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("hs_ack", 32'(host_ack), 32'd1);
        chk("hs_done_held", 32'(done), 32'd1);
        host_req = 1'b0;
        chk("hs_first", 32'(log_q.size() > 0 ? log_q[0] : 24'h0), 32'h60559A);
        if (log_q.size() > 0) void'(log_q.pop_front());
        k = 0;
        while (done && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("hs_rerun", 32'(done), 32'd0);
        wait_fin("hs", 6000);
        check_run("hs");

        // Full table with no end marker: index wrap ends the run
        for (int i = 0; i < N; i++) rom[i] = {8'h70 + 8'(i), 8'(i)};
        do_run("wrap");

        // Randomized tables and NACK patterns
        for (int t = 0; t < 6; t++) begin
            clear_env();
            len = $urandom_range(1, 12);
            for (int i = 0; i < N; i++) begin
                if (i >= len) rom[i] = 16'hFF00;
                else if ($urandom_range(0, 5) == 0) rom[i] = {8'hFE, 8'($urandom_range(0, 2))};
                else rom[i] = {8'($urandom_range(0, 253)), 8'($urandom)};
            end
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 9) > 6) nack_left[rom[i][15:8]] = $urandom_range(1, 4);
                if ($urandom_range(0, 19) == 0) nack_always[rom[i][15:8]] = 1;
            end
            do_run("rnd");
        end

        // Dead core: table run and host request both time out
        clear_env();
        dead = 1;
        fill_end();
        rom[0] = 16'h4001;
        log_q.delete();
        pulse_start();
        k = 0;
        while (!err && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("to_err", 32'(err), 32'd1);
        chk("to_early", 32'(k >= int'(TO) - 5), 32'd1);
        chk("to_late", 32'(k <= int'(TO) + 15), 32'd1);
        chk("to_trig", 32'(i2c_start_trigger), 32'd0);
        chk("to_idx", 32'(err_idx), 32'd0);
        chk("to_done", 32'(done), 32'd0);
        host_txn("hto", 1'b1, 8'h0A, 8'h00, rd);
        chk("hto_data", 32'(rd), 32'h100);
        chk("hto_n", 32'(log_q.size()), 32'd0);

        // Async reset in the middle of WAIT
        dead = 0;
        rom[0] = 16'h5005;
        pulse_start();
        k = 0;
        while (!(i2c_busy && !i2c_start_trigger) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("mid_wait", 32'(i2c_busy && !i2c_start_trigger), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_trig", 32'(i2c_start_trigger), 32'd0);
        chk("arst_addr", 32'(i2c_addr), 32'h60);
        chk("arst_cmd", 32'(i2c_cmd), 32'd0);
        chk("arst_tx", 32'(i2c_tx_data), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        chk("arst_tbladdr", 32'(tbl_addr), 32'd0);
        chk("arst_hack", 32'(host_ack), 32'd0);
        ref_run();
        log_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_fin("post", 6000);
        check_run("post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
